// File: rtl/tlb_refill_walker_pkg.sv
// Shared types for the Sv32 page-table walker: walker states, PTE layout,
// TLB entry and the CSR/access types seen on its ports.
package TlbWalkerTypes;

  localparam int unsigned PADDR_WIDTH   = 34;
  localparam int unsigned PTE_SIZE_LOG2 = 2;
  localparam int unsigned LEVELS        = 2;

  typedef enum logic [1:0] {
    AccessLoad  = 2'd0,
    AccessStore = 2'd1,
    AccessFetch = 2'd2
  } MemoryAccessType;

  typedef struct packed {
    logic        mode;
    logic [8:0]  asid;
    logic [21:0] ppn;
  } csr_satp_t;

  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [7:0]  flags;
    logic [21:0] pageNumber;
  } TlbEntry;

  typedef struct packed {
    logic [21:0] ppn;
    logic [1:0]  rsw;
    logic        D;
    logic        A;
    logic        G;
    logic        U;
    logic        X;
    logic        W;
    logic        R;
    logic        V;
  } Pte;

  typedef enum logic [3:0] {
    Idle,
    ReqL1,
    WaitL1,
    ReqL0,
    WaitL0,
    Check,
    ReqWb,
    WaitWb,
    Refill,
    Drain
  } WalkerState;

endpackage

// File: rtl/tlb_refill_walker_pte_decoder.sv
// Combinational classification of one Sv32 PTE at a given walk level.
module PteDecoder
  import TlbWalkerTypes::*;
(
  input  Pte                          pte,
  input  logic [$clog2(LEVELS)-1:0]   level,
  output logic                        isInvalid,
  output logic                        isLeaf,
  output logic                        isMisaligned,
  output logic [21:0]                 nextPpn
);

  logic unusedPteBits;

  always_comb begin
    isInvalid    = !pte.V || (!pte.R && pte.W);
    isLeaf       = pte.R || pte.X;
    // a superpage leaf must have its low PPN slice clear
    isMisaligned = isLeaf && (level != '0) && (pte.ppn[9:0] != '0);
    nextPpn      = pte.ppn;
  end

  assign unusedPteBits = ^{pte.rsw, pte.D, pte.A, pte.G, pte.U};

endmodule

// File: rtl/tlb_refill_walker.sv
// Sv32 two-level page-table walker: reads PTEs, optionally writes back A/D,
// then emits one TLB entry (translation or fault) per accepted miss.
module tlb_refill_walker
  import TlbWalkerTypes::*;
#(
  parameter bit          UpdateAccessDirty = 1'b1,
  parameter int unsigned MemAddrWidth      = PADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic [19:0]             reqVpn,
  input  MemoryAccessType         reqAccessType,
  input  csr_satp_t               csrSatp,
  input  logic                    flush,
  output logic                    tlbWriteEnable,
  output logic [19:0]             tlbWriteKey,
  output TlbEntry                 tlbWriteValue,
  output logic                    done,
  output logic                    memReadEnable,
  output logic                    memWriteEnable,
  output logic [MemAddrWidth-1:0] memAddr,
  output logic [31:0]             memWriteValue,
  input  logic                    memReady,
  input  logic                    memDone,
  input  logic [31:0]             memReadValue
);

  WalkerState                state, stateNext;
  logic [19:0]               vpnQ;
  MemoryAccessType           accessQ;
  logic [21:0]               rootPpnQ;
  Pte                        pteQ;
  logic [MemAddrWidth-1:0]   leafAddrQ;
  logic                      faultQ;
  logic [21:0]               pageQ;

  logic                      decInvalid, decLeaf, decMisaligned;
  logic [21:0]               decNextPpn;
  logic [$clog2(LEVELS)-1:0] decLevel;
  logic                      needA, needD, accept;
  logic [MemAddrWidth-1:0]   l1Addr, l0Addr;
  logic                      unusedSatpBits;

  assign decLevel = (state == WaitL1);
  assign accept   = (state == Idle) && reqValid && !flush;
  assign needA    = !pteQ.A;
  assign needD    = (accessQ == AccessStore) && pteQ.W && !pteQ.D;
  assign l1Addr   = MemAddrWidth'({rootPpnQ, vpnQ[19:10], {PTE_SIZE_LOG2{1'b0}}});
  assign l0Addr   = MemAddrWidth'({pteQ.ppn, vpnQ[9:0], {PTE_SIZE_LOG2{1'b0}}});
  assign tlbWriteKey    = vpnQ;
  assign unusedSatpBits = ^{csrSatp.mode, csrSatp.asid};

  PteDecoder decoder (
    .pte          (Pte'(memReadValue)),
    .level        (decLevel),
    .isInvalid    (decInvalid),
    .isLeaf       (decLeaf),
    .isMisaligned (decMisaligned),
    .nextPpn      (decNextPpn)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= Idle;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext      = state;
    reqReady       = 1'b0;
    memReadEnable  = 1'b0;
    memWriteEnable = 1'b0;
    memAddr        = '0;
    memWriteValue  = '0;
    tlbWriteEnable = 1'b0;
    done           = 1'b0;
    tlbWriteValue  = '0;
    case (state)
      Idle: begin
        reqReady = 1'b1;
        if (accept) stateNext = ReqL1;
      end
      ReqL1, ReqL0, ReqWb: begin
        memReadEnable  = (state != ReqWb);
        memWriteEnable = (state == ReqWb);
        memAddr        = (state == ReqL1) ? l1Addr : (state == ReqL0) ? l0Addr : leafAddrQ;
        memWriteValue  = (state == ReqWb) ? pteQ : '0;
        // a request the memory took in the flush cycle still owes a response
        if (flush)         stateNext = memReady ? Drain : Idle;
        else if (memReady) stateNext = (state == ReqL1) ? WaitL1 : (state == ReqL0) ? WaitL0 : WaitWb;
      end
      WaitL1: begin
        if (memDone) begin
          if (flush)                           stateNext = Idle;
          else if (decInvalid || decMisaligned) stateNext = Refill;
          else if (decLeaf)                    stateNext = Check;
          else                                 stateNext = ReqL0;
        end else if (flush) stateNext = Drain;
      end
      WaitL0: begin
        if (memDone) begin
          if (flush)                        stateNext = Idle;
          else if (decInvalid || !decLeaf)  stateNext = Refill;
          else                              stateNext = Check;
        end else if (flush) stateNext = Drain;
      end
      WaitWb: begin
        if (memDone)    stateNext = flush ? Idle : Refill;
        else if (flush) stateNext = Drain;
      end
      Check: begin
        if (flush)                                        stateNext = Idle;
        else if ((needA || needD) && UpdateAccessDirty)   stateNext = ReqWb;
        else                                              stateNext = Refill;
      end
      Refill: begin
        if (!flush) begin
          tlbWriteEnable           = 1'b1;
          done                     = 1'b1;
          tlbWriteValue.valid      = 1'b1;
          tlbWriteValue.fault      = faultQ;
          tlbWriteValue.flags      = pteQ[7:0];
          tlbWriteValue.pageNumber = faultQ ? '0 : pageQ;
        end
        stateNext = Idle;
      end
      Drain: begin
        if (memDone) stateNext = Idle;
      end
      default: stateNext = Idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpnQ      <= '0;
      accessQ   <= AccessLoad;
      rootPpnQ  <= '0;
      pteQ      <= '0;
      leafAddrQ <= '0;
      faultQ    <= 1'b0;
      pageQ     <= '0;
    end else begin
      case (state)
        Idle: if (accept) begin
          vpnQ     <= reqVpn;
          accessQ  <= reqAccessType;
          rootPpnQ <= csrSatp.ppn;
          faultQ   <= 1'b0;
        end
        ReqL1, ReqL0: if (memReady) leafAddrQ <= memAddr;
        WaitL1: if (memDone) begin
          pteQ   <= Pte'(memReadValue);
          faultQ <= decInvalid || decMisaligned;
          pageQ  <= {decNextPpn[21:10], vpnQ[9:0]};
        end
        WaitL0: if (memDone) begin
          pteQ   <= Pte'(memReadValue);
          faultQ <= decInvalid || !decLeaf;
          pageQ  <= decNextPpn;
        end
        // the updated PTE doubles as the writeback data and the refill flags
        Check: if (needA || needD) begin
          if (UpdateAccessDirty) begin
            pteQ.A <= 1'b1;
            pteQ.D <= pteQ.D || needD;
          end else begin
            faultQ <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed bench for tlb_refill_walker: drives requests and a single-cycle
// memory from one sequence, checking every observation against fixed values.
module tb_tlb_refill_walker;
  import TlbWalkerTypes::*;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            reqValid = 1'b0;
  logic            reqReady;
  logic [19:0]     reqVpn = '0;
  MemoryAccessType reqAccessType = AccessLoad;
  csr_satp_t       csrSatp = '0;
  logic            flush = 1'b0;
  logic            tlbWriteEnable;
  logic [19:0]     tlbWriteKey;
  TlbEntry         tlbWriteValue;
  logic            done;
  logic            memReadEnable;
  logic            memWriteEnable;
  logic [33:0]     memAddr;
  logic [31:0]     memWriteValue;
  logic            memReady = 1'b0;
  logic            memDone = 1'b0;
  logic [31:0]     memReadValue = '0;

  int          compared = 0;
  int          mismatched = 0;
  int unsigned cyc = 0;
  int unsigned c0, cDone;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tlb_refill_walker #(.UpdateAccessDirty(1'b1), .MemAddrWidth(34)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqVpn(reqVpn),
    .reqAccessType(reqAccessType), .csrSatp(csrSatp), .flush(flush),
    .tlbWriteEnable(tlbWriteEnable), .tlbWriteKey(tlbWriteKey), .tlbWriteValue(tlbWriteValue),
    .done(done), .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
    .memAddr(memAddr), .memWriteValue(memWriteValue), .memReady(memReady),
    .memDone(memDone), .memReadValue(memReadValue)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkIdle(input string tag);
    check({tag, " reqReady"}, 64'(reqReady), 64'd1);
    check({tag, " memRd"}, 64'(memReadEnable), 64'd0);
    check({tag, " memWr"}, 64'(memWriteEnable), 64'd0);
    check({tag, " memAddr"}, 64'(memAddr), 64'd0);
    check({tag, " memWdata"}, 64'(memWriteValue), 64'd0);
    check({tag, " tlbWe"}, 64'(tlbWriteEnable), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " key"}, 64'(tlbWriteKey), 64'd0);
    check({tag, " entry"}, 64'(tlbWriteValue), 64'd0);
  endtask

  task automatic issue(input string tag, input logic [19:0] vpn, input MemoryAccessType acc,
                       input logic [21:0] ppn, output int unsigned cAcc);
    check({tag, " reqReady"}, 64'(reqReady), 64'd1);
    reqValid = 1'b1; reqVpn = vpn; reqAccessType = acc;
    csrSatp = '0; csrSatp.mode = 1'b1; csrSatp.ppn = ppn;
    cAcc = cyc;
    tick();
    reqValid = 1'b0; reqVpn = ~vpn; csrSatp.ppn = ~ppn;
  endtask

  task automatic memAccept(input string tag, input bit isWrite, input logic [33:0] addr,
                           input logic [31:0] wdata);
    int n = 0;
    while (!(isWrite ? memWriteEnable : memReadEnable) && n < 20) begin tick(); n++; end
    check({tag, " req"}, 64'(isWrite ? memWriteEnable : memReadEnable), 64'd1);
    check({tag, " addr"}, 64'(memAddr), 64'(addr));
    if (isWrite) check({tag, " wdata"}, 64'(memWriteValue), 64'(wdata));
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    memDone = 1'b1; memReadValue = data;
    tick();
    memDone = 1'b0; memReadValue = '0;
  endtask

  task automatic memRead(input string tag, input logic [33:0] addr, input logic [31:0] data);
    memAccept(tag, 1'b0, addr, '0);
    respond(data);
  endtask

  task automatic waitRefill(input string tag, input logic [19:0] key, input logic fault,
                            input logic [7:0] flags, input logic [21:0] page,
                            output int unsigned cEnd);
    int n = 0;
    int busy = 0;
    while (!tlbWriteEnable && n < 20) begin
      if (memReadEnable || memWriteEnable) busy++;
      tick(); n++;
    end
    cEnd = cyc;
    check({tag, " tlbWe"}, 64'(tlbWriteEnable), 64'd1);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " key"}, 64'(tlbWriteKey), 64'(key));
    check({tag, " valid"}, 64'(tlbWriteValue.valid), 64'd1);
    check({tag, " fault"}, 64'(tlbWriteValue.fault), 64'(fault));
    check({tag, " flags"}, 64'(tlbWriteValue.flags), 64'(flags));
    check({tag, " page"}, 64'(tlbWriteValue.pageNumber), 64'(page));
    check({tag, " extra mem req"}, 64'(busy), 64'd0);
    tick();
    check({tag, " tlbWe pulse"}, 64'(tlbWriteEnable), 64'd0);
    check({tag, " idle again"}, 64'(reqReady), 64'd1);
  endtask

  task automatic basicWalk(input string tag);
    issue(tag, 20'h12345, AccessLoad, 22'h40000, c0);
    memRead({tag, " L1"}, 34'h0_4000_0120, 32'h2000_0001);
    memRead({tag, " L0"}, 34'h0_8000_0D14, 32'h0030_00CF);
    waitRefill(tag, 20'h12345, 1'b0, 8'hCF, 22'h000C00, cDone);
  endtask

  initial begin
    repeat (2) tick();
    checkIdle("reset");
    rst = 1'b1;
    tick();

    // Two-level walk, also checks the 7-cycle minimum latency
    basicWalk("t1");
    check("t1 latency", 64'(cDone - c0 + 1), 64'd7);

    // Root at ppn 0x00100 gives L1 address 0x0010_0120
    issue("t1b", 20'h12345, AccessLoad, 22'h00100, c0);
    memRead("t1b L1", 34'h0_0010_0120, 32'h2000_0001);
    memRead("t1b L0", 34'h0_8000_0D14, 32'h0030_00CF);
    waitRefill("t1b", 20'h12345, 1'b0, 8'hCF, 22'h000C00, cDone);

    // Store with A=0,D=0: writeback sets both
    issue("t2", 20'h12345, AccessStore, 22'h40000, c0);
    memRead("t2 L1", 34'h0_4000_0120, 32'h2000_0001);
    memRead("t2 L0", 34'h0_8000_0D14, 32'h0030_0007);
    memAccept("t2 wb", 1'b1, 34'h0_8000_0D14, 32'h0030_00C7);
    respond('0);
    waitRefill("t2", 20'h12345, 1'b0, 8'hC7, 22'h000C00, cDone);

    // Load with A=1,D=0: no writeback needed
    issue("t2b", 20'h12345, AccessLoad, 22'h40000, c0);
    memRead("t2b L1", 34'h0_4000_0120, 32'h2000_0001);
    memRead("t2b L0", 34'h0_8000_0D14, 32'h0030_0047);
    waitRefill("t2b", 20'h12345, 1'b0, 8'h47, 22'h000C00, cDone);

    // Store to read-only page with A=1: D not required
    issue("t2c", 20'h12345, AccessStore, 22'h40000, c0);
    memRead("t2c L1", 34'h0_4000_0120, 32'h2000_0001);
    memRead("t2c L0", 34'h0_8000_0D14, 32'h0030_004B);
    waitRefill("t2c", 20'h12345, 1'b0, 8'h4B, 22'h000C00, cDone);

    // Load with A=0,D=1: only A is added
    issue("t2d", 20'h12345, AccessLoad, 22'h40000, c0);
    memRead("t2d L1", 34'h0_4000_0120, 32'h2000_0001);
    memRead("t2d L0", 34'h0_8000_0D14, 32'h0030_0087);
    memAccept("t2d wb", 1'b1, 34'h0_8000_0D14, 32'h0030_00C7);
    respond('0);
    waitRefill("t2d", 20'h12345, 1'b0, 8'hC7, 22'h000C00, cDone);

    // Misaligned superpage: fault after a single read
    issue("t3", 20'h12345, AccessLoad, 22'h40000, c0);
    memRead("t3 L1", 34'h0_4000_0120, 32'h0000_04CF);
    waitRefill("t3", 20'h12345, 1'b1, 8'hCF, 22'h0, cDone);

    // Aligned superpage: page = {ppn[21:10], vpn0}
    issue("t3b", 20'h12345, AccessLoad, 22'h40000, c0);
    memRead("t3b L1", 34'h0_4000_0120, 32'h00C0_00CF);
    waitRefill("t3b", 20'h12345, 1'b0, 8'hCF, 22'h003345, cDone);

    // Reserved W-without-R encoding at L1
    issue("t3c", 20'h12345, AccessLoad, 22'h40000, c0);
    memRead("t3c L1", 34'h0_4000_0120, 32'h0000_0005);
    waitRefill("t3c", 20'h12345, 1'b1, 8'h05, 22'h0, cDone);

    // Invalid and non-leaf L0 entries
    issue("t4a", 20'h12345, AccessLoad, 22'h40000, c0);
    memRead("t4a L1", 34'h0_4000_0120, 32'h2000_0001);
    memRead("t4a L0", 34'h0_8000_0D14, 32'h0000_0000);
    waitRefill("t4a", 20'h12345, 1'b1, 8'h00, 22'h0, cDone);
    issue("t4b", 20'h12345, AccessLoad, 22'h40000, c0);
    memRead("t4b L1", 34'h0_4000_0120, 32'h2000_0001);
    memRead("t4b L0", 34'h0_8000_0D14, 32'h2000_0001);
    waitRefill("t4b", 20'h12345, 1'b1, 8'h01, 22'h0, cDone);

    // Flush in WaitL0, response three cycles later
    issue("t5", 20'h12345, AccessLoad, 22'h40000, c0);
    memRead("t5 L1", 34'h0_4000_0120, 32'h2000_0001);
    memAccept("t5 L0", 1'b0, 34'h0_8000_0D14, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5 drain rd", 64'(memReadEnable), 64'd0);
    check("t5 drain busy", 64'(reqReady), 64'd0);
    tick();
    check("t5 drain tlbWe", 64'(tlbWriteEnable), 64'd0);
    tick();
    memDone = 1'b1; memReadValue = 32'h0030_00CF;
    check("t5 busy at memDone", 64'(reqReady), 64'd0);
    tick();
    memDone = 1'b0; memReadValue = '0;
    check("t5 ready after memDone", 64'(reqReady), 64'd1);
    check("t5 no tlbWe", 64'(tlbWriteEnable), 64'd0);
    basicWalk("t5 next");

    // Flush in ReqL1 before the memory accepts
    issue("t5b", 20'h12345, AccessLoad, 22'h40000, c0);
    check("t5b rd", 64'(memReadEnable), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5b ready", 64'(reqReady), 64'd1);
    check("t5b rd dropped", 64'(memReadEnable), 64'd0);

    // Flush together with reqValid in Idle: not accepted
    reqValid = 1'b1; flush = 1'b1; reqVpn = 20'h12345;
    tick();
    reqValid = 1'b0; flush = 1'b0;
    check("t5c ready", 64'(reqReady), 64'd1);
    check("t5c no rd", 64'(memReadEnable), 64'd0);

    // Flush in Refill suppresses the write
    issue("t5d", 20'h12345, AccessLoad, 22'h40000, c0);
    memRead("t5d L1", 34'h0_4000_0120, 32'h2000_0001);
    memRead("t5d L0", 34'h0_8000_0D14, 32'h0030_00CF);
    tick();
    flush = 1'b1;
    #1;
    check("t5d tlbWe", 64'(tlbWriteEnable), 64'd0);
    check("t5d done", 64'(done), 64'd0);
    tick();
    flush = 1'b0;
    check("t5d ready", 64'(reqReady), 64'd1);

    // Reset asserted in ReqWb
    issue("t6", 20'h12345, AccessStore, 22'h40000, c0);
    memRead("t6 L1", 34'h0_4000_0120, 32'h2000_0001);
    memRead("t6 L0", 34'h0_8000_0D14, 32'h0030_0007);
    tick();
    check("t6 in ReqWb", 64'(memWriteEnable), 64'd1);
    rst = 1'b0;
    #1;
    checkIdle("t6 reset");
    tick();
    rst = 1'b1;
    tick();
    basicWalk("t6 next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
